ct_lsu_amr_ctrl: RTL and testbench

- Sequencer in front of the AMR stream detector.
- Decides when AMR write-allocate cancel and L2 mem-set may be applied to outgoing stores.
- Counts non-allocating stores still in flight on the bus.
- Drains them before granting instruction-cache ops (icc) or CP0 no-op requests, so cache maintenance never races a non-allocated write.

---
 rtl/ct_lsu_amr_ctrl_if.sv | 41 ++++
 rtl/ct_lsu_amr_ctrl.sv | 123 ++++++++++++
 tb/tb_ct_lsu_amr_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ct_lsu_amr_ctrl_if.sv
// Signal bundle between the AMR sequencer and its surroundings: CP0/icc requests,
// detector indications, WMB/bus store traffic, and the qualified results.
interface ct_lsu_amr_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             cp0_lsu_amr;
  logic             cp0_lsu_no_op_req;
  logic             icc_req;
  logic             amr_wa_cancel;
  logic             amr_l2_mem_set;
  logic             wmb_nwa_issue;
  logic             bus_nwa_resp;

  logic             amr_en_eff;
  logic             amr_wa_cancel_gate;
  logic             amr_l2_mem_set_gate;
  logic             amr_icc_grant;
  logic             amr_no_op_ack;
  logic [CNT_W-1:0] amr_nwa_cnt;
  logic             amr_cnt_err;
  logic [1:0]       amr_ctrl_state;
  logic             amr_ctrl_clk_en;

  modport slave (
    input  cp0_lsu_amr, cp0_lsu_no_op_req, icc_req,
    input  amr_wa_cancel, amr_l2_mem_set,
    input  wmb_nwa_issue, bus_nwa_resp,
    output amr_en_eff, amr_wa_cancel_gate, amr_l2_mem_set_gate,
    output amr_icc_grant, amr_no_op_ack,
    output amr_nwa_cnt, amr_cnt_err, amr_ctrl_state, amr_ctrl_clk_en
  );

  modport master (
    output cp0_lsu_amr, cp0_lsu_no_op_req, icc_req,
    output amr_wa_cancel, amr_l2_mem_set,
    output wmb_nwa_issue, bus_nwa_resp,
    input  amr_en_eff, amr_wa_cancel_gate, amr_l2_mem_set_gate,
    input  amr_icc_grant, amr_no_op_ack,
    input  amr_nwa_cnt, amr_cnt_err, amr_ctrl_state, amr_ctrl_clk_en
  );
endinterface

// File: rtl/ct_lsu_amr_ctrl.sv
// AMR sequencer: qualifies write-allocate cancel / L2 mem-set, tracks in-flight
// non-allocating stores, and drains them before granting icc or CP0 no-op.
module ct_lsu_amr_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic                  amr_clk,
  input  logic                  cpurst_b,
  ct_lsu_amr_ctrl_if.slave      amr_if
);

  typedef enum logic [1:0] {
    AMR_OFF   = 2'b00,
    AMR_RUN   = 2'b01,
    AMR_DRAIN = 2'b10,
    AMR_GRANT = 2'b11
  } amr_state_e;

  amr_state_e       state_q;
  amr_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_set;

  logic pend;
  logic cnt_full;
  logic cnt_zero;
  logic cnt_inc;
  logic cnt_dec;

  assign pend     = amr_if.icc_req | amr_if.cp0_lsu_no_op_req;
  assign cnt_full = &cnt_q;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_inc  = amr_if.wmb_nwa_issue & ~amr_if.bus_nwa_resp;
  assign cnt_dec  = amr_if.bus_nwa_resp  & ~amr_if.wmb_nwa_issue;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge amr_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= AMR_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AMR_OFF: begin
        if (pend) begin
          state_d = AMR_DRAIN;
        end else if (amr_if.cp0_lsu_amr) begin
          state_d = AMR_RUN;
        end
      end
      AMR_RUN: begin
        if (pend || !amr_if.cp0_lsu_amr) begin
          state_d = AMR_DRAIN;
        end
      end
      AMR_DRAIN: begin
        // Registered count only: an issue/resp landing this cycle is seen next cycle.
        if (cnt_zero) begin
          state_d = pend ? AMR_GRANT : AMR_OFF;
        end
      end
      AMR_GRANT: begin
        if (!pend) begin
          state_d = AMR_OFF;
        end
      end
      default: state_d = AMR_OFF;
    endcase
  end

  // Saturating up/down count; a simultaneous issue and response cancel out.
  always_comb begin
    cnt_d   = cnt_q;
    err_set = 1'b0;
    if (cnt_inc) begin
      if (cnt_full) begin
        err_set = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_dec) begin
      if (cnt_zero) begin
        err_set = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge amr_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | err_set;
    end
  end

  // Gates are only live in RUN, so they fall one cycle after pend rises.
  assign amr_if.amr_en_eff          = (state_q == AMR_RUN) & amr_if.cp0_lsu_amr;
  assign amr_if.amr_wa_cancel_gate  = (state_q == AMR_RUN) & amr_if.amr_wa_cancel & ~cnt_full;
  assign amr_if.amr_l2_mem_set_gate = amr_if.amr_wa_cancel_gate & amr_if.amr_l2_mem_set;
  assign amr_if.amr_icc_grant       = (state_q == AMR_GRANT) & amr_if.icc_req;
  assign amr_if.amr_no_op_ack       = (state_q == AMR_GRANT) & amr_if.cp0_lsu_no_op_req;
  assign amr_if.amr_nwa_cnt         = cnt_q;
  assign amr_if.amr_cnt_err         = err_q;
  assign amr_if.amr_ctrl_state      = state_q;

  // Clock must keep running whenever anything could change state or count.
  assign amr_if.amr_ctrl_clk_en = amr_if.cp0_lsu_amr | pend
                                | amr_if.wmb_nwa_issue | amr_if.bus_nwa_resp
                                | (state_q != AMR_OFF) | ~cnt_zero;

endmodule

// File: tb/tb_ct_lsu_amr_ctrl.sv
// Bench for ct_lsu_amr_ctrl: hand-written vector table, directed corner sequences,
// and random traffic against a behavioural model of the sequencer.
module tb_ct_lsu_amr_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_OFF   = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_GRANT = 3;

  typedef struct packed {
    logic amr;
    logic noop;
    logic icc;
    logic wac;
    logic l2;
    logic iss;
    logic rsp;
  } in_t;

  typedef struct packed {
    logic       en;
    logic       wag;
    logic       l2g;
    logic       grant;
    logic       ack;
    logic [3:0] cnt;
    logic       err;
    logic [1:0] st;
    logic       clken;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic amr_clk  = 1'b0;
  logic cpurst_b = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  int   m_mode;
  int   m_cnt;
  bit   m_err;

  ct_lsu_amr_ctrl_if #(.CNT_W(CNT_W)) amr_if ();

  ct_lsu_amr_ctrl #(.CNT_W(CNT_W)) dut (
    .amr_clk  (amr_clk),
    .cpurst_b (cpurst_b),
    .amr_if   (amr_if.slave)
  );

  always #5 amr_clk = ~amr_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic out_t get_dut();
    out_t o;
    o.en    = amr_if.amr_en_eff;
    o.wag   = amr_if.amr_wa_cancel_gate;
    o.l2g   = amr_if.amr_l2_mem_set_gate;
    o.grant = amr_if.amr_icc_grant;
    o.ack   = amr_if.amr_no_op_ack;
    o.cnt   = amr_if.amr_nwa_cnt;
    o.err   = amr_if.amr_cnt_err;
    o.st    = amr_if.amr_ctrl_state;
    o.clken = amr_if.amr_ctrl_clk_en;
    return o;
  endfunction

  // Behavioural expectation of the outputs for the current model state and inputs.
  function automatic out_t model_out(input in_t in);
    out_t o;
    bit   pend = in.icc || in.noop;
    o.en    = (m_mode == M_RUN) && in.amr;
    o.wag   = (m_mode == M_RUN) && in.wac && (m_cnt != CNT_MAX);
    o.l2g   = o.wag && in.l2;
    o.grant = (m_mode == M_GRANT) && in.icc;
    o.ack   = (m_mode == M_GRANT) && in.noop;
    o.cnt   = 4'(m_cnt);
    o.err   = m_err;
    o.st    = 2'(m_mode);
    o.clken = in.amr || pend || in.iss || in.rsp || (m_mode != M_OFF) || (m_cnt != 0);
    return o;
  endfunction

  task automatic model_step(input in_t in);
    bit pend = in.icc || in.noop;
    int d    = int'(in.iss) - int'(in.rsp);
    int nxt  = m_mode;
    case (m_mode)
      M_OFF:   nxt = pend ? M_DRAIN : (in.amr ? M_RUN : M_OFF);
      M_RUN:   nxt = (pend || !in.amr) ? M_DRAIN : M_RUN;
      M_DRAIN: nxt = (m_cnt != 0) ? M_DRAIN : (pend ? M_GRANT : M_OFF);
      default: nxt = pend ? M_GRANT : M_OFF;
    endcase
    m_mode = nxt;
    if (d == 1) begin
      if (m_cnt == CNT_MAX) m_err = 1'b1;
      else m_cnt = m_cnt + 1;
    end else if (d == -1) begin
      if (m_cnt == 0) m_err = 1'b1;
      else m_cnt = m_cnt - 1;
    end
  endtask

  task automatic drive(input in_t in);
    amr_if.cp0_lsu_amr       = in.amr;
    amr_if.cp0_lsu_no_op_req = in.noop;
    amr_if.icc_req           = in.icc;
    amr_if.amr_wa_cancel     = in.wac;
    amr_if.amr_l2_mem_set    = in.l2;
    amr_if.wmb_nwa_issue     = in.iss;
    amr_if.bus_nwa_resp      = in.rsp;
  endtask

  // Entered at posedge+1: apply inputs, compare at the falling edge, advance.
  task automatic cyc(input in_t in, input out_t exp, input string name);
    drive(in);
    #4;
    check(name, 32'(get_dut()), 32'(exp));
    model_step(in);
    @(posedge amr_clk);
    #1;
  endtask

  task automatic mcyc(input in_t in, input string name);
    drive(in);
    cyc(in, model_out(in), name);
  endtask

  task automatic do_reset();
    drive('0);
    cpurst_b = 1'b0;
    m_mode   = M_OFF;
    m_cnt    = 0;
    m_err    = 1'b0;
    repeat (2) @(posedge amr_clk);
    #1;
    check("reset_state", 32'(get_dut()), 32'(0));
    cpurst_b = 1'b1;
  endtask

  vec_t tbl [13];

  initial begin
    in_t  r;
    out_t o;

    // amr=1, wa_cancel+l2, 3 issues, icc request, 3 responses, grant, release.
    tbl[0]  = '{in: 7'b1000000, exp: {5'b00000, 4'd0, 1'b0, 2'b00, 1'b1}};
    tbl[1]  = '{in: 7'b1001110, exp: {5'b11100, 4'd0, 1'b0, 2'b01, 1'b1}};
    tbl[2]  = '{in: 7'b1001110, exp: {5'b11100, 4'd1, 1'b0, 2'b01, 1'b1}};
    tbl[3]  = '{in: 7'b1001110, exp: {5'b11100, 4'd2, 1'b0, 2'b01, 1'b1}};
    tbl[4]  = '{in: 7'b1011100, exp: {5'b11100, 4'd3, 1'b0, 2'b01, 1'b1}};
    tbl[5]  = '{in: 7'b1011101, exp: {5'b00000, 4'd3, 1'b0, 2'b10, 1'b1}};
    tbl[6]  = '{in: 7'b1011101, exp: {5'b00000, 4'd2, 1'b0, 2'b10, 1'b1}};
    tbl[7]  = '{in: 7'b1011101, exp: {5'b00000, 4'd1, 1'b0, 2'b10, 1'b1}};
    tbl[8]  = '{in: 7'b1011100, exp: {5'b00000, 4'd0, 1'b0, 2'b10, 1'b1}};
    tbl[9]  = '{in: 7'b1011100, exp: {5'b00010, 4'd0, 1'b0, 2'b11, 1'b1}};
    tbl[10] = '{in: 7'b1001000, exp: {5'b00000, 4'd0, 1'b0, 2'b11, 1'b1}};
    tbl[11] = '{in: 7'b1000000, exp: {5'b00000, 4'd0, 1'b0, 2'b00, 1'b1}};
    tbl[12] = '{in: 7'b1001000, exp: {5'b11000, 4'd0, 1'b0, 2'b01, 1'b1}};

    drive('0);
    #2;
    do_reset();
    @(posedge amr_clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].in, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Same-cycle issue and response at cnt=2.
    do_reset();
    mcyc(7'b1000000, "sim_run");
    mcyc(7'b1000010, "sim_iss0");
    mcyc(7'b1000010, "sim_iss1");
    mcyc(7'b1000011, "sim_both");
    check("sim_cnt2", 32'(amr_if.amr_nwa_cnt), 32'd2);
    check("sim_noerr", 32'(amr_if.amr_cnt_err), 32'd0);

    // Counter saturation at 15 and overflow error.
    do_reset();
    mcyc(7'b1000000, "ovf_run");
    for (int i = 0; i < CNT_MAX; i++) mcyc(7'b1001010, $sformatf("ovf_iss%0d", i));
    check("ovf_cnt15", 32'(amr_if.amr_nwa_cnt), 32'd15);
    check("ovf_gate_off", 32'(amr_if.amr_wa_cancel_gate), 32'd0);
    check("ovf_noerr", 32'(amr_if.amr_cnt_err), 32'd0);
    mcyc(7'b1001010, "ovf_iss16");
    check("ovf_hold", 32'(amr_if.amr_nwa_cnt), 32'd15);
    check("ovf_err", 32'(amr_if.amr_cnt_err), 32'd1);

    // Underflow at cnt=0 is sticky until reset.
    do_reset();
    mcyc(7'b0000001, "udf_rsp");
    check("udf_cnt0", 32'(amr_if.amr_nwa_cnt), 32'd0);
    check("udf_err", 32'(amr_if.amr_cnt_err), 32'd1);
    for (int i = 0; i < 3; i++) mcyc(7'b1000110, $sformatf("udf_more%0d", i));
    check("udf_sticky", 32'(amr_if.amr_cnt_err), 32'd1);
    do_reset();
    check("udf_cleared", 32'(amr_if.amr_cnt_err), 32'd0);

    // icc and no-op together: both granted, GRANT held until both drop.
    mcyc(7'b1000000, "dual_off");
    mcyc(7'b1110000, "dual_req");
    mcyc(7'b1110000, "dual_drain");
    o = get_dut();
    check("dual_grant", 32'({o.grant, o.ack, o.st}), 32'(4'b1111));
    mcyc(7'b1110000, "dual_grant_cyc");
    mcyc(7'b1100000, "dual_icc_drop");
    check("dual_still_grant", 32'(amr_if.amr_ctrl_state), 32'd3);
    check("dual_ack_only", 32'({amr_if.amr_icc_grant, amr_if.amr_no_op_ack}), 32'(2'b01));
    mcyc(7'b1000000, "dual_all_drop");
    check("dual_off", 32'(amr_if.amr_ctrl_state), 32'd0);

    // cp0_lsu_amr cleared with stores in flight: RUN -> DRAIN -> OFF.
    do_reset();
    mcyc(7'b1000000, "dis_off");
    mcyc(7'b1000010, "dis_iss");
    mcyc(7'b0000000, "dis_clear");
    mcyc(7'b0000001, "dis_rsp");
    mcyc(7'b0000000, "dis_drain0");
    check("dis_off", 32'(amr_if.amr_ctrl_state), 32'd0);

    // Asynchronous reset in DRAIN with cnt=5.
    do_reset();
    mcyc(7'b1000000, "ar_off");
    for (int i = 0; i < 5; i++) mcyc(7'b1000010, $sformatf("ar_iss%0d", i));
    mcyc(7'b0000000, "ar_to_drain");
    check("ar_pre", 32'({amr_if.amr_ctrl_state, amr_if.amr_nwa_cnt}), 32'({2'b10, 4'd5}));
    #2;
    cpurst_b = 1'b0;
    #1;
    check("ar_async", 32'(get_dut()), 32'(0));
    do_reset();

    // Random traffic against the model.
    @(posedge amr_clk);
    #1;
    for (int i = 0; i < 800; i++) begin
      r.amr  = ($urandom_range(0, 9) < 8);
      r.noop = ($urandom_range(0, 9) < 1);
      r.icc  = ($urandom_range(0, 9) < 2);
      r.wac  = 1'($urandom_range(0, 1));
      r.l2   = 1'($urandom_range(0, 1));
      r.iss  = ($urandom_range(0, 9) < 4);
      r.rsp  = ($urandom_range(0, 9) < 3);
      mcyc(r, $sformatf("rnd%0d", i));
      if (i == 400) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
